l4_mac_seq_ctrl: RTL and testbench

- Job sequencer for one output-stationary L4 MAC tile.
- Accepts a job descriptor (precision, reduction length K), pulls K operand sets from the operand buffer through a req/ack handshake, and drives the tile's prec/accum_en/operand-gate controls.
- Handles bit-serial step timing.
- Presents the finished accumulator through a valid/ready result handshake.
- Sits between the layer scheduler/operand buffers and the L4 MAC tile.

---
 rtl/l4_mac_seq_ctrl_pkg.sv | 42 ++++
 rtl/l4_mac_seq_ctrl_step_timer.sv | 28 ++
 rtl/l4_mac_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_l4_mac_seq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l4_mac_seq_ctrl_pkg.sv
// Shared types and precision helpers for the L4 MAC job sequencer.
package l4_mac_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_HOLD,
        S_DRAIN,
        S_OUT
    } state_t;

    localparam logic [3:0] P88 = 4'b0000;
    localparam logic [3:0] P84 = 4'b0010;
    localparam logic [3:0] P82 = 4'b0011;
    localparam logic [3:0] P44 = 4'b1010;
    localparam logic [3:0] P22 = 4'b1111;

    localparam int unsigned STEP_W = 5;

    function automatic logic prec_legal(input logic [3:0] prec);
        case (prec)
            P88, P84, P82, P44, P22: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [STEP_W-1:0] step_cycles(input logic [3:0] prec, input logic serial);
        logic [STEP_W-1:0] s;
        s = 5'd1;
        if (serial) begin
            case (prec)
                P88:      s = 5'd16;
                P84:      s = 5'd8;
                P82, P44: s = 5'd4;
                default:  s = 5'd1;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/l4_mac_seq_ctrl_step_timer.sv
// Loadable down-counter timing the HOLD cycles of one bit-serial step.
module mac_step_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    // Asserted on the cycle whose decrement brings the count to zero.
    assign done = (count == W'(1));

endmodule

// File: rtl/l4_mac_seq_ctrl.sv
// Job sequencer for one output-stationary L4 MAC tile: operand pulls, step timing, result handshake.
module l4_mac_seq_ctrl
    import l4_mac_seq_ctrl_pkg::*;
#(
    parameter int unsigned KW     = 10,
    parameter bit          SERIAL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [3:0]    cfg_prec,
    input  logic [KW-1:0] cfg_k,
    output logic          cfg_err,
    output logic          op_req,
    input  logic          op_ack,
    output logic          mac_rst,
    output logic [3:0]    mac_prec,
    output logic          mac_accum_en,
    output logic          mac_gate,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          abort,
    output logic          busy
);

    state_t              state, state_nxt;
    logic [3:0]          prec_q;
    logic [KW-1:0]       remaining;
    logic                first;
    logic                hold_accum;
    logic                tile_clr;
    logic                err_q;
    logic [STEP_W-1:0]   step_len;
    logic                cfg_ok;
    logic                ack_run;
    logic                step_done;

    assign step_len = step_cycles(prec_q, SERIAL);
    assign cfg_ok   = cfg_valid && (cfg_k != '0) && prec_legal(cfg_prec);
    assign ack_run  = (state == S_RUN) && op_ack && !abort;

    mac_step_timer #(.W(STEP_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ack_run),
        .load_val (step_len - STEP_W'(1)),
        .en       (state == S_HOLD),
        .done     (step_done)
    );

    // tile_clr keeps the post-reset IDLE cycle distinct so the tile is cleared once after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prec_q     <= '0;
            remaining  <= '0;
            first      <= 1'b0;
            hold_accum <= 1'b0;
            tile_clr   <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            tile_clr <= 1'b0;
            err_q    <= (state == S_IDLE) && cfg_valid && !cfg_ok;
            if (state == S_IDLE && cfg_ok) begin
                prec_q    <= cfg_prec;
                remaining <= cfg_k;
                first     <= 1'b1;
            end
            if (ack_run) begin
                first      <= 1'b0;
                hold_accum <= ~first;
                remaining  <= remaining - KW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (cfg_ok) state_nxt = S_START;
                S_START: state_nxt = S_RUN;
                S_RUN: begin
                    if (op_ack) begin
                        if (step_len != STEP_W'(1))    state_nxt = S_HOLD;
                        else if (remaining == KW'(1))  state_nxt = S_DRAIN;
                    end
                end
                S_HOLD:  if (step_done) state_nxt = (remaining == '0) ? S_DRAIN : S_RUN;
                S_DRAIN: state_nxt = S_OUT;
                S_OUT:   if (out_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready    = 1'b0;
        op_req       = 1'b0;
        mac_rst      = 1'b0;
        mac_accum_en = 1'b1;
        mac_gate     = 1'b1;
        out_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (tile_clr) begin
                    mac_rst      = 1'b1;
                    mac_accum_en = 1'b0;
                end
            end
            S_START: begin
                mac_rst      = 1'b1;
                mac_accum_en = 1'b0;
            end
            S_RUN: begin
                op_req       = 1'b1;
                mac_gate     = ~(op_ack && !abort);
                mac_accum_en = ~first;
            end
            S_HOLD: begin
                mac_gate     = 1'b0;
                mac_accum_en = hold_accum;
            end
            S_OUT:   out_valid = 1'b1;
            default: ;
        endcase
    end

    assign cfg_err  = err_q;
    assign mac_prec = prec_q;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_l4_mac_seq_ctrl.sv
// Self-checking bench for l4_mac_seq_ctrl: config table, timeline model of jobs, and abort/reset sequences.
module tb_l4_mac_seq_ctrl;

    localparam int KW = 10;

    typedef struct packed {
        logic       cfg_ready;
        logic       cfg_err;
        logic       op_req;
        logic       mac_rst;
        logic [3:0] mac_prec;
        logic       mac_accum_en;
        logic       mac_gate;
        logic       out_valid;
        logic       busy;
    } outs_t;

    typedef struct {
        logic [3:0]    prec;
        logic [KW-1:0] k;
        logic          exp_err;
        logic          exp_busy;
        logic          exp_mac_rst;
    } cfg_vec_t;

    logic          clk = 1'b0;
    logic          rst, cfg_valid, op_ack, out_ready, abort, sel;
    logic [3:0]    cfg_prec;
    logic [KW-1:0] cfg_k;
    logic [15:0]   a_in, w_in;
    logic [31:0]   z;
    outs_t         o0, o1, m;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    assign m = sel ? o1 : o0;

    l4_mac_seq_ctrl #(.KW(KW), .SERIAL(1'b0)) u0 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(o0.cfg_ready),
        .cfg_prec(cfg_prec), .cfg_k(cfg_k), .cfg_err(o0.cfg_err), .op_req(o0.op_req),
        .op_ack(op_ack), .mac_rst(o0.mac_rst), .mac_prec(o0.mac_prec),
        .mac_accum_en(o0.mac_accum_en), .mac_gate(o0.mac_gate), .out_valid(o0.out_valid),
        .out_ready(out_ready), .abort(abort), .busy(o0.busy)
    );

    l4_mac_seq_ctrl #(.KW(KW), .SERIAL(1'b1)) u1 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(o1.cfg_ready),
        .cfg_prec(cfg_prec), .cfg_k(cfg_k), .cfg_err(o1.cfg_err), .op_req(o1.op_req),
        .op_ack(op_ack), .mac_rst(o1.mac_rst), .mac_prec(o1.mac_prec),
        .mac_accum_en(o1.mac_accum_en), .mac_gate(o1.mac_gate), .out_valid(o1.out_valid),
        .out_ready(out_ready), .abort(abort), .busy(o1.busy)
    );

    // Behavioural one-cycle-per-step tile attached to the SERIAL=0 instance.
    always @(posedge clk) begin
        if (o0.mac_rst)
            z <= '0;
        else if (!o0.mac_accum_en)
            z <= o0.mac_gate ? 32'd0 : a_in * w_in;
        else
            z <= z + (o0.mac_gate ? 32'd0 : a_in * w_in);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; op_ack = 1'b0; out_ready = 1'b0; abort = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    function automatic int unsigned ref_step(input logic [3:0] p, input bit ser);
        if (!ser) return 1;
        case (p)
            4'b0000:          return 16;
            4'b0010:          return 8;
            4'b0011, 4'b1010: return 4;
            default:          return 1;
        endcase
    endfunction

    // Timeline model: RUN waits for an ack, then each accepted set occupies S cycles; DRAIN, then OUT.
    task automatic run_job(input bit s, input logic [3:0] prec, input int k, input int pct,
                           input int hold_out, input int st_lo, input int st_hi);
        int unsigned S;
        int          lo[$], hi[$];
        bit          ackq[$];
        int          cur, outc, last, L;
        int          ph[], st[];
        logic [31:0] sum;
        string       tag;
        sel = s;
        do_reset();
        S = ref_step(prec, s);
        if (pct < 1) pct = 100;
        ackq = {1'b0, 1'b0};
        cur = 2;
        for (int i = 0; i < k; i++) begin
            lo.push_back(cur);
            forever begin
                while (ackq.size() <= cur)
                    ackq.push_back((ackq.size() >= st_lo && ackq.size() <= st_hi) ? 1'b0
                                   : ($urandom_range(99) < pct));
                if (ackq[cur]) break;
                cur++;
            end
            hi.push_back(cur);
            cur += S;
        end
        outc = cur + 1;
        last = outc + hold_out;
        L    = last + 2;
        ph = new[L];
        st = new[L];
        for (int c = 0; c < L; c++) begin ph[c] = 0; st[c] = 0; end
        for (int i = 0; i < k; i++) begin
            for (int c = lo[i]; c <= hi[i]; c++) begin ph[c] = 1; st[c] = i; end
            for (int c = hi[i] + 1; c < hi[i] + int'(S); c++) begin ph[c] = 2; st[c] = i; end
        end
        while (ackq.size() < L) ackq.push_back($urandom_range(99) < pct);
        sum = '0;
        for (int c = 0; c < L; c++) begin
            cfg_valid = (c == 0) || (c > outc && c < last);
            cfg_prec  = prec;
            cfg_k     = (c == 0) ? KW'(k) : KW'(5);
            op_ack    = ackq[c];
            out_ready = (c == last);
            a_in      = 16'($urandom_range(255));
            w_in      = 16'($urandom_range(255));
            if (ph[c] == 1 && c == hi[st[c]]) sum += a_in * w_in;
            @(negedge clk);
            tag = $sformatf("s%0d p%b k%0d c%0d", s, prec, k, c);
            chk({"op_req ", tag}, m.op_req, ph[c] == 1);
            chk({"gate ", tag}, m.mac_gate, (ph[c] == 1) ? !ackq[c] : (ph[c] != 2));
            if (ph[c] != 0) chk({"accum_en ", tag}, m.mac_accum_en, st[c] != 0);
            chk({"out_valid ", tag}, m.out_valid, c >= outc && c <= last);
            chk({"busy ", tag}, m.busy, c >= 1 && c <= last);
            chk({"cfg_ready ", tag}, m.cfg_ready, c == 0 || c > last);
            chk({"mac_rst ", tag}, m.mac_rst, c == 1);
            if (c >= 1 && c <= last) chk({"mac_prec ", tag}, m.mac_prec, prec);
            if (!s && c >= outc && c <= last) chk({"z ", tag}, z, sum);
            step();
        end
        cfg_valid = 1'b0; op_ack = 1'b0; out_ready = 1'b0;
    endtask

    logic [3:0] legal [5] = '{4'b0000, 4'b0010, 4'b0011, 4'b1010, 4'b1111};
    cfg_vec_t   vecs  [10];

    initial begin
        sel = 1'b0; a_in = '0; w_in = '0; cfg_prec = '0; cfg_k = '0;
        rst = 1'b1; cfg_valid = 1'b0; op_ack = 1'b0; out_ready = 1'b0; abort = 1'b0;

        vecs[0] = '{4'b0000, 10'd4,    1'b0, 1'b1, 1'b1};
        vecs[1] = '{4'b0000, 10'd0,    1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b0110, 10'd3,    1'b1, 1'b0, 1'b0};
        vecs[3] = '{4'b0010, 10'd1,    1'b0, 1'b1, 1'b1};
        vecs[4] = '{4'b0011, 10'd1023, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{4'b1010, 10'd2,    1'b0, 1'b1, 1'b1};
        vecs[6] = '{4'b1111, 10'd7,    1'b0, 1'b1, 1'b1};
        vecs[7] = '{4'b0001, 10'd5,    1'b1, 1'b0, 1'b0};
        vecs[8] = '{4'b1111, 10'd0,    1'b1, 1'b0, 1'b0};
        vecs[9] = '{4'b1011, 10'd1,    1'b1, 1'b0, 1'b0};

        // Reset values while rst is held.
        step();
        @(negedge clk);
        chk("rst cfg_ready", o0.cfg_ready, 1'b1);
        chk("rst mac_rst", o0.mac_rst, 1'b1);
        chk("rst accum_en", o0.mac_accum_en, 1'b0);
        chk("rst gate", o0.mac_gate, 1'b1);
        chk("rst busy", o0.busy, 1'b0);
        chk("rst cfg_err", o0.cfg_err, 1'b0);

        // Descriptor acceptance table.
        foreach (vecs[i]) begin
            sel = 1'b0;
            do_reset();
            cfg_valid = 1'b1; cfg_prec = vecs[i].prec; cfg_k = vecs[i].k;
            @(negedge clk);
            chk($sformatf("tbl%0d cfg_ready", i), m.cfg_ready, 1'b1);
            step();
            cfg_valid = 1'b0; abort = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d cfg_err", i), m.cfg_err, vecs[i].exp_err);
            chk($sformatf("tbl%0d busy", i), m.busy, vecs[i].exp_busy);
            chk($sformatf("tbl%0d mac_rst", i), m.mac_rst, vecs[i].exp_mac_rst);
            step();
            abort = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d err_pulse", i), m.cfg_err, 1'b0);
            chk($sformatf("tbl%0d idle", i), m.busy, 1'b0);
        end

        // Directed jobs from the plan, then randomized ones.
        run_job(1'b0, 4'b0000, 4, 100, 0, -1, -1);
        run_job(1'b0, 4'b0000, 3, 100, 0, 3, 4);
        run_job(1'b1, 4'b0010, 2, 100, 0, -1, -1);
        run_job(1'b0, 4'b1010, 3, 100, 5, -1, -1);
        run_job(1'b0, 4'b0011, 1023, 100, 0, -1, -1);
        for (int r = 0; r < 14; r++)
            run_job(1'($urandom_range(1)), legal[$urandom_range(4)], int'($urandom_range(6, 1)),
                    int'($urandom_range(100, 30)), int'($urandom_range(3)), -1, -1);

        // Abort mid-RUN on the SERIAL=0 tile, then a k=1 job must yield a single product.
        sel = 1'b0;
        do_reset();
        cfg_valid = 1'b1; cfg_prec = 4'b0000; cfg_k = 10'd4; op_ack = 1'b1; a_in = 16'd3; w_in = 16'd3;
        step();
        cfg_valid = 1'b0;
        step(); step(); step();
        abort = 1'b1;
        @(negedge clk);
        chk("ab0 busy_before", m.busy, 1'b1);
        step();
        abort = 1'b0; op_ack = 1'b0; cfg_valid = 1'b1; cfg_k = 10'd1;
        @(negedge clk);
        chk("ab0 busy", m.busy, 1'b0);
        chk("ab0 op_req", m.op_req, 1'b0);
        chk("ab0 out_valid", m.out_valid, 1'b0);
        chk("ab0 cfg_ready", m.cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("ab0 start_rst", m.mac_rst, 1'b1);
        step();
        op_ack = 1'b1; a_in = 16'd5; w_in = 16'd7;
        @(negedge clk);
        chk("ab0 run_req", m.op_req, 1'b1);
        chk("ab0 run_accum", m.mac_accum_en, 1'b0);
        step();
        op_ack = 1'b0;
        step();
        @(negedge clk);
        chk("ab0 out_valid2", m.out_valid, 1'b1);
        chk("ab0 z", z, 32'd35);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("ab0 idle", m.busy, 1'b0);

        // Abort while in HOLD of a bit-serial prec=0000 job.
        sel = 1'b1;
        do_reset();
        cfg_valid = 1'b1; cfg_prec = 4'b0000; cfg_k = 10'd3; op_ack = 1'b1;
        step();
        cfg_valid = 1'b0;
        step(); step(); step(); step();
        abort = 1'b1;
        @(negedge clk);
        chk("ab1 hold_req", m.op_req, 1'b0);
        chk("ab1 hold_gate", m.mac_gate, 1'b0);
        chk("ab1 hold_busy", m.busy, 1'b1);
        step();
        abort = 1'b0; op_ack = 1'b0;
        @(negedge clk);
        chk("ab1 busy", m.busy, 1'b0);
        chk("ab1 op_req", m.op_req, 1'b0);
        chk("ab1 out_valid", m.out_valid, 1'b0);
        chk("ab1 gate", m.mac_gate, 1'b1);

        // Synchronous reset in the middle of a RUN.
        sel = 1'b0;
        do_reset();
        cfg_valid = 1'b1; cfg_prec = 4'b1010; cfg_k = 10'd8; op_ack = 1'b1;
        step();
        cfg_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("mid cfg_ready", m.cfg_ready, 1'b1);
        chk("mid op_req", m.op_req, 1'b0);
        chk("mid mac_rst", m.mac_rst, 1'b1);
        chk("mid mac_prec", m.mac_prec, 4'b0000);
        chk("mid accum_en", m.mac_accum_en, 1'b0);
        chk("mid gate", m.mac_gate, 1'b1);
        chk("mid out_valid", m.out_valid, 1'b0);
        chk("mid busy", m.busy, 1'b0);
        rst = 1'b0; op_ack = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
